// File: rtl/icon_sched_pkg.sv
// Shared types and constants for the world-map icon scheduler.
// Orientation codes, FSM states, icon codes and the outline helper.
package icon_sched_pkg;

   typedef enum logic [2:0] {
      NORTH     = 3'b000,
      NORTHEAST = 3'b001,
      EAST      = 3'b010,
      SOUTHEAST = 3'b011,
      SOUTH     = 3'b100,
      SOUTHWEST = 3'b101,
      WEST      = 3'b110,
      NORTHWEST = 3'b111
   } orient_e;

   localparam int ICON_DIM = 16;
   localparam int ICON_BPP = 2;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      WAIT_FRAME = 2'b01,
      ACTIVE     = 2'b10
   } state_e;

   localparam logic [3:0] ICON_TRANSPARENT = 4'b0000;
   localparam logic [3:0] DBG_BOX_CODE     = 4'b0111;

   typedef struct packed {
      orient_e    orient;
      logic [7:0] locX;
      logic [7:0] locY;
   } bot_shadow_t;

   function automatic logic onOutline(
      input logic [3:0] relX,
      input logic [3:0] relY
   );
      return (relX == 4'd0) || (relX == 4'(ICON_DIM - 1)) ||
             (relY == 4'd0) || (relY == 4'(ICON_DIM - 1));
   endfunction

endpackage

// File: rtl/icon_sched_if.sv
// Icon bitmap ROM port: scheduler is master, ROM is slave.
// rom_addr/rom_en out of master, rom_data (registered, 1-cycle) back.
interface icon_sched_if;

   logic [7:0]  rom_addr;
   logic        rom_en;
   logic [31:0] rom_data;

   modport master (
      output rom_addr,
      output rom_en,
      input  rom_data
   );

   modport slave (
      input  rom_addr,
      input  rom_en,
      output rom_data
   );

endinterface

// File: rtl/icon_sched_hit_calc.sv
// Per-bot 16x16 bounding-box hit test in 13-bit two's complement.
// In: pixel row/column, world loc. Out: hit, relX[3:0], relY[3:0].
module icon_hit_calc
   import icon_sched_pkg::*;
#(
   parameter int SCALE_X     = 8,
   parameter int SCALE_Y     = 6,
   parameter int ICON_OFFSET = 8
) (
   input  logic [11:0] pixelRow,
   input  logic [11:0] pixelColumn,
   input  logic [7:0]  locX,
   input  logic [7:0]  locY,
   output logic        hit,
   output logic [3:0]  relX,
   output logic [3:0]  relY
);

   logic [12:0] fullX;
   logic [12:0] fullY;

   assign fullX = {1'b0, pixelColumn}
                - 13'(locX) * 13'(SCALE_X)
                + 13'(ICON_OFFSET);
   assign fullY = {1'b0, pixelRow}
                - 13'(locY) * 13'(SCALE_Y)
                + 13'(ICON_OFFSET);

   // Negative results have bit 12 set, so an unsigned compare
   // rejects them without any wrap-around aliasing.
   assign hit  = (fullX < 13'(ICON_DIM)) && (fullY < 13'(ICON_DIM));
   assign relX = fullX[3:0];
   assign relY = fullY[3:0];

endmodule

// File: rtl/icon_sched.sv
// Two-bot sprite scheduler/arbiter sharing one icon ROM; 3-cycle icon.
// Ports: clock/reset_n, DTG coords, bot regs, ROM master, icon, collision.
// Optional ICON_SCHED_DBG_BOX_EN draws box outlines on transparent px.
module icon_sched
   import icon_sched_pkg::*;
#(
   parameter int SCALE_X     = 8,
   parameter int SCALE_Y     = 6,
   parameter int ICON_OFFSET = 8,
   parameter int PRIO_ROTATE = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        frame_tick,
   input  logic [11:0] pixel_row,
   input  logic [11:0] pixel_column,
   input  logic [7:0]  botA_info,
   input  logic [7:0]  botB_info,
   input  logic [7:0]  botA_locx,
   input  logic [7:0]  botA_locy,
   input  logic [7:0]  botB_locx,
   input  logic [7:0]  botB_locy,
   input  logic        upd_req,
   icon_sched_if.master rom,
   output logic [3:0]  icon,
   output logic        collision,
   input  logic        coll_clr
);

   state_e      stateQ;
   state_e      stateD;
   bot_shadow_t shA;
   bot_shadow_t shB;
   logic        pendQ;
   logic        prioQ;
   logic        collQ;

   logic        hitA;
   logic        hitB;
   logic [3:0]  relXA;
   logic [3:0]  relYA;
   logic [3:0]  relXB;
   logic [3:0]  relYB;

   logic        act;
   logic        anyHit;
   logic        bothHit;
   logic        selB;
   logic [7:0]  addrD;

   logic [7:0]  romAddrQ;
   logic        romEnQ;
   logic        s1Valid;
   logic        s1Owner;
   logic [3:0]  s1RelX;
   logic        s2Valid;
   logic        s2Owner;
   logic [3:0]  s2RelX;
   logic [1:0]  pix;
   logic [3:0]  iconD;
   logic [3:0]  iconQ;

   logic        unusedInfo;

   assign unusedInfo = ^{botA_info[7:3], botB_info[7:3]};

   icon_hit_calc #(
      .SCALE_X     (SCALE_X),
      .SCALE_Y     (SCALE_Y),
      .ICON_OFFSET (ICON_OFFSET)
   ) hitCalcA (
      .pixelRow    (pixel_row),
      .pixelColumn (pixel_column),
      .locX        (shA.locX),
      .locY        (shA.locY),
      .hit         (hitA),
      .relX        (relXA),
      .relY        (relYA)
   );

   icon_hit_calc #(
      .SCALE_X     (SCALE_X),
      .SCALE_Y     (SCALE_Y),
      .ICON_OFFSET (ICON_OFFSET)
   ) hitCalcB (
      .pixelRow    (pixel_row),
      .pixelColumn (pixel_column),
      .locX        (shB.locX),
      .locY        (shB.locY),
      .hit         (hitB),
      .relX        (relXB),
      .relY        (relYB)
   );

   // FSM
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         IDLE:       if (enable) stateD = WAIT_FRAME;
         WAIT_FRAME: if (frame_tick) stateD = ACTIVE;
         ACTIVE:     stateD = ACTIVE;
         default:    stateD = IDLE;
      endcase
      if (!enable) stateD = IDLE;
   end

   // Shadows only move on a frame boundary, so a frame never tears.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shA   <= '0;
         shB   <= '0;
         pendQ <= 1'b0;
      end else if (frame_tick && pendQ) begin
         shA   <= '{orient: orient_e'(botA_info[2:0]),
                    locX: botA_locx, locY: botA_locy};
         shB   <= '{orient: orient_e'(botB_info[2:0]),
                    locX: botB_locx, locY: botB_locy};
         pendQ <= upd_req;
      end else if (upd_req) begin
         pendQ <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prioQ <= 1'b0;
      end else if (stateQ == ACTIVE && frame_tick) begin
         prioQ <= ~prioQ;
      end
   end

   // Arbitration: prioQ=1 means B currently owns overlaps.
   assign act     = (stateQ == ACTIVE) && enable;
   assign anyHit  = hitA || hitB;
   assign bothHit = hitA && hitB;
   assign selB    = hitB &&
                    (!hitA || ((PRIO_ROTATE != 0) && prioQ));
   assign addrD   = selB ? {1'b1, shB.orient, relYB}
                         : {1'b0, shA.orient, relYA};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         collQ <= 1'b0;
      end else if (act && bothHit) begin
         collQ <= 1'b1;
      end else if (coll_clr) begin
         collQ <= 1'b0;
      end
   end

`ifdef ICON_SCHED_DBG_BOX_EN
   logic outline;
   logic s1Edge;
   logic s2Edge;

   assign outline = (hitA && onOutline(relXA, relYA)) ||
                    (hitB && onOutline(relXB, relYB));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1Edge <= 1'b0;
         s2Edge <= 1'b0;
      end else if (!enable) begin
         s1Edge <= 1'b0;
         s2Edge <= 1'b0;
      end else begin
         s1Edge <= act && outline;
         s2Edge <= s1Edge;
      end
   end
`endif

   assign pix = rom.rom_data[{s2RelX, 1'b0} +: ICON_BPP];

   always_comb begin
      iconD = ICON_TRANSPARENT;
      if (s2Valid && pix != 2'b00) begin
         iconD = {1'b1, s2Owner, pix};
      end
`ifdef ICON_SCHED_DBG_BOX_EN
      else if (s2Edge) begin
         iconD = DBG_BOX_CODE;
      end
`endif
   end

   // S1: ROM request, S2: ROM output register, S3: icon.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         romAddrQ <= '0;
         romEnQ   <= 1'b0;
         s1Valid  <= 1'b0;
         s1Owner  <= 1'b0;
         s1RelX   <= '0;
         s2Valid  <= 1'b0;
         s2Owner  <= 1'b0;
         s2RelX   <= '0;
         iconQ    <= ICON_TRANSPARENT;
      end else if (!enable) begin
         romEnQ   <= 1'b0;
         s1Valid  <= 1'b0;
         s2Valid  <= 1'b0;
         iconQ    <= ICON_TRANSPARENT;
      end else begin
         romEnQ   <= act && anyHit;
         s1Valid  <= act && anyHit;
         if (act && anyHit) begin
            romAddrQ <= addrD;
            s1Owner  <= selB;
            s1RelX   <= selB ? relXB : relXA;
         end
         s2Valid  <= s1Valid;
         s2Owner  <= s1Owner;
         s2RelX   <= s1RelX;
         iconQ    <= iconD;
      end
   end

   assign rom.rom_addr = romAddrQ;
   assign rom.rom_en   = romEnQ;
   assign icon         = iconQ;
   assign collision    = collQ;

endmodule
